// File: rtl/conv_pio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pio_pkg
// Description : Shared types and constants for the PIO-driven convolution
//               sequencer: state encoding and status-word bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pio_pkg;

    // Explicit 3-bit encoding; the raw value is exported in status[7:5].
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DONE   = 3'd3
    } state_t;

    // status = {state[2:0], overflow, fifo_level[2:0], coef_loaded}
    localparam int c_ST_STATE_HI = 7;
    localparam int c_ST_STATE_LO = 5;
    localparam int c_ST_OVF      = 4;
    localparam int c_ST_LVL_HI   = 3;
    localparam int c_ST_LVL_LO   = 1;
    localparam int c_ST_COEF     = 0;

endpackage
`default_nettype wire

// File: rtl/conv_pix_fifo.sv
`default_nettype none
// ============================================================================
// Module      : conv_pix_fifo
// Description : Synchronous pixel FIFO with first-word-fall-through read.
//               A write on a full FIFO is accepted only when a read happens
//               in the same cycle.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_clr           - synchronous flush (pointers to zero)
//               i_wr_en/i_wr_data, i_rd_en/o_rd_data - push / pop
//               o_full, o_empty, o_level - occupancy flags and count
// Revision    : 1.0 - initial release
// ============================================================================
module conv_pix_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clr,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL_LEVEL = (c_AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_do_wr;
    logic             w_do_rd;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_level   = r_wr_ptr - r_rd_ptr;
    assign o_full    = (o_level == c_FULL_LEVEL);
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_do_rd   = i_rd_en & ~o_empty;
    assign w_do_wr   = i_wr_en & (~o_full | w_do_rd);
    assign o_rd_data = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage is not reset; the consumer gates the head word with o_empty.
    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wr_ptr[c_AW-1:0]] <= i_wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/conv_pio_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : conv_pio_sequencer
// Description : Turns software-toggled PIO levels into a coefficient load
//               sequence followed by a valid/ready pixel stream for a
//               convolution filter, one IMG_W x IMG_H frame per start edge.
// Ports       : clk_clk, reset_reset - clock, synchronous active-high reset
//               pio_data/pio_write_en/pio_start/pio_reset_cnt - PIO inputs
//               coef_data/coef_idx/coef_we - coefficient write port
//               pix_data/pix_valid/pix_ready - pixel stream
//               frame_done, busy, status - frame and status reporting
// Revision    : 1.0 - initial release
// ============================================================================
module conv_pio_sequencer
    import conv_pio_pkg::*;
#(
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int NUM_COEF   = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic [7:0] pio_data,
    input  logic       pio_write_en,
    input  logic       pio_start,
    input  logic       pio_reset_cnt,
    output logic [7:0] coef_data,
    output logic [3:0] coef_idx,
    output logic       coef_we,
    output logic [7:0] pix_data,
    output logic       pix_valid,
    input  logic       pix_ready,
    output logic       frame_done,
    output logic       busy,
    output logic [7:0] status
);

    localparam int c_TOTAL  = IMG_W * IMG_H;
    localparam int c_CNT_W  = $clog2(c_TOTAL + 1);
    localparam int c_FIFO_AW = $clog2(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_TOTAL_CNT   = c_CNT_W'(c_TOTAL);
    localparam logic [c_CNT_W-1:0] c_LAST_PIX    = c_CNT_W'(c_TOTAL - 1);
    localparam logic [3:0]         c_LAST_COEF   = 4'(NUM_COEF - 1);

    // PIO capture stage plus previous-sample registers for edge detection.
    logic [7:0] r_pio_data;
    logic       r_we;
    logic       r_we_prev;
    logic       r_start;
    logic       r_start_prev;
    logic       r_rcnt;
    logic       w_we_edge;
    logic       w_start_edge;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [3:0]           r_coef_cnt;
    logic [c_CNT_W-1:0]   r_pix_cnt;
    logic [c_CNT_W-1:0]   r_push_cnt;
    logic                 r_overflow;
    logic                 r_coef_loaded;
    logic                 r_coef_we;
    logic [3:0]           r_coef_idx;
    logic [7:0]           r_coef_data;

    logic                 w_push_req;
    logic                 w_stream_start;
    logic                 w_fifo_wr;
    logic                 w_pop;
    logic                 w_ovf_set;
    logic [7:0]           w_fifo_head;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [c_FIFO_AW:0]   w_fifo_level;
    logic [2:0]           w_level3;

    // The capture registers run even while pio_reset_cnt is high so that a
    // level already high at release is not mistaken for a fresh edge.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_pio_data   <= '0;
            r_we         <= 1'b0;
            r_we_prev    <= 1'b0;
            r_start      <= 1'b0;
            r_start_prev <= 1'b0;
            r_rcnt       <= 1'b0;
        end else begin
            r_pio_data   <= pio_data;
            r_we         <= pio_write_en;
            r_we_prev    <= r_we;
            r_start      <= pio_start;
            r_start_prev <= r_start;
            r_rcnt       <= pio_reset_cnt;
        end
    end

    assign w_we_edge    = r_we & ~r_we_prev;
    assign w_start_edge = r_start & ~r_start_prev;

    assign w_pop     = ~w_fifo_empty & pix_ready;
    assign w_fifo_wr = w_push_req & (~w_fifo_full | w_pop);
    // Any stream byte strobe that does not land in the FIFO is an overflow,
    // whether the FIFO is full or the frame has already received all bytes.
    assign w_ovf_set = (r_state == ST_STREAM) & w_we_edge & ~r_rcnt & ~w_fifo_wr;

    always_comb begin
        w_state_nxt    = r_state;
        w_push_req     = 1'b0;
        w_stream_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_we_edge && (r_coef_cnt == c_LAST_COEF)) w_state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (w_start_edge) begin
                    w_state_nxt    = ST_STREAM;
                    w_stream_start = 1'b1;
                    // A byte strobed together with start becomes pixel 0.
                    w_push_req     = w_we_edge;
                end
            end
            ST_STREAM: begin
                w_push_req = w_we_edge && (r_push_cnt != c_TOTAL_CNT);
                if (w_pop && (r_pix_cnt == c_LAST_PIX)) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_ARMED;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (r_rcnt) begin
            w_state_nxt    = ST_IDLE;
            w_push_req     = 1'b0;
            w_stream_start = 1'b0;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset || r_rcnt) begin
            r_state       <= ST_IDLE;
            r_coef_cnt    <= '0;
            r_pix_cnt     <= '0;
            r_push_cnt    <= '0;
            r_overflow    <= 1'b0;
            r_coef_loaded <= 1'b0;
            r_coef_we     <= 1'b0;
            r_coef_idx    <= '0;
            r_coef_data   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_coef_we <= 1'b0;

            if ((r_state == ST_IDLE) && w_we_edge) begin
                r_coef_we   <= 1'b1;
                r_coef_idx  <= r_coef_cnt;
                r_coef_data <= r_pio_data;
                r_coef_cnt  <= r_coef_cnt + 1'b1;
                if (r_coef_cnt == c_LAST_COEF) r_coef_loaded <= 1'b1;
            end

            if (w_stream_start) begin
                r_pix_cnt  <= '0;
                r_push_cnt <= w_fifo_wr ? c_CNT_W'(1) : '0;
            end else begin
                if (w_fifo_wr) r_push_cnt <= r_push_cnt + 1'b1;
                if (w_pop && (r_state == ST_STREAM)) r_pix_cnt <= r_pix_cnt + 1'b1;
            end

            if (w_ovf_set) r_overflow <= 1'b1;
        end
    end

    conv_pix_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk_clk),
        .rst       (reset_reset),
        .i_clr     (r_rcnt),
        .i_wr_en   (w_fifo_wr),
        .i_wr_data (r_pio_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_fifo_head),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_level   (w_fifo_level)
    );

    assign w_level3 = 3'(w_fifo_level);

    assign coef_we    = r_coef_we;
    assign coef_idx   = r_coef_idx;
    assign coef_data  = r_coef_data;
    assign pix_valid  = ~w_fifo_empty;
    // FIFO storage is never reset, so the head is masked when nothing is valid.
    assign pix_data   = w_fifo_empty ? 8'h00 : w_fifo_head;
    assign frame_done = (r_state == ST_DONE);
    assign busy       = (r_state == ST_STREAM);

    always_comb begin
        status = '0;
        status[c_ST_STATE_HI:c_ST_STATE_LO] = r_state;
        status[c_ST_OVF]                    = r_overflow;
        status[c_ST_LVL_HI:c_ST_LVL_LO]     = w_level3;
        status[c_ST_COEF]                   = r_coef_loaded;
    end

endmodule
`default_nettype wire
